// File: rtl/regfile_sb_if.sv
// Register-file access bundle: ID read/issue ports, WB write port, PDU debug read.
interface regfile_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] ra0;
  logic [DW-1:0] rd0;
  logic [AW-1:0] ra1;
  logic [DW-1:0] rd1;
  logic [AW-1:0] ra_dbg;
  logic [DW-1:0] rd_dbg;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          sb_set;
  logic [AW-1:0] sb_wa;
  logic          busy0;
  logic          busy1;
  logic          init_done;

  modport slave (
    input  ra0, ra1, ra_dbg, we, wa, wd, sb_set, sb_wa,
    output rd0, rd1, rd_dbg, busy0, busy1, init_done
  );

  modport master (
    output ra0, ra1, ra_dbg, we, wa, wd, sb_set, sb_wa,
    input  rd0, rd1, rd_dbg, busy0, busy1, init_done
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read register file with pending-write scoreboard. A sequenced init walk
// preloads every entry so the storage array itself carries no reset.
module regfile_sb #(
  parameter int          DW       = 32,
  parameter int          AW       = 5,
  parameter int          ZERO_REG = 1,
  parameter int          SP_IDX   = 2,
  parameter logic [31:0] SP_INIT  = 32'h2ffc,
  parameter int          GP_IDX   = 3,
  parameter logic [31:0] GP_INIT  = 32'h1800
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**AW;
  localparam logic [DW-1:0] SP_V = DW'(SP_INIT);
  localparam logic [DW-1:0] GP_V = DW'(GP_INIT);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DEPTH-1:0]  sb_q, sb_d;
  logic              init_done_q;
  logic [DW-1:0]     mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [DW-1:0]     mem_wd;
  logic              run;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic hit(input logic we, input logic [AW-1:0] wa,
                               input logic [AW-1:0] ra);
    return we && (wa == ra);
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sb_d    = sb_q;
    mem_we  = 1'b0;
    mem_wa  = bus.wa;
    mem_wd  = bus.wd;
    case (state_q)
      INIT: begin
        mem_we = 1'b1;
        mem_wa = idx_q;
        if (idx_q == AW'(SP_IDX))      mem_wd = SP_V;
        else if (idx_q == AW'(GP_IDX)) mem_wd = GP_V;
        else                           mem_wd = '0;
        sb_d[idx_q] = 1'b0;
        if (idx_q == AW'(DEPTH - 1)) state_d = RUN;
        else                         idx_d   = idx_q + AW'(1);
      end
      RUN: begin
        mem_we = bus.we && !is_zero(bus.wa);
        if (bus.we) sb_d[bus.wa] = 1'b0;
        // Applied after the clear so a same-index issue overrides the retire.
        if (bus.sb_set && !is_zero(bus.sb_wa)) sb_d[bus.sb_wa] = 1'b1;
      end
      default: state_d = INIT;
    endcase
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      idx_q       <= '0;
      sb_q        <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sb_q        <= sb_d;
      init_done_q <= (state_d == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign run = (state_q == RUN);

  always_comb begin
    bus.rd0 = '0;
    bus.rd1 = '0;
    bus.rd_dbg = '0;
    if (run) begin
      if (is_zero(bus.ra0))                   bus.rd0 = '0;
      else if (hit(bus.we, bus.wa, bus.ra0))  bus.rd0 = bus.wd;
      else                                    bus.rd0 = mem[bus.ra0];
      if (is_zero(bus.ra1))                   bus.rd1 = '0;
      else if (hit(bus.we, bus.wa, bus.ra1))  bus.rd1 = bus.wd;
      else                                    bus.rd1 = mem[bus.ra1];
      if (is_zero(bus.ra_dbg))                   bus.rd_dbg = '0;
      else if (hit(bus.we, bus.wa, bus.ra_dbg))  bus.rd_dbg = bus.wd;
      else                                       bus.rd_dbg = mem[bus.ra_dbg];
    end
  end

  assign bus.busy0 = run && sb_q[bus.ra0] && !hit(bus.we, bus.wa, bus.ra0) &&
                     !is_zero(bus.ra0);
  assign bus.busy1 = run && sb_q[bus.ra1] && !hit(bus.we, bus.wa, bus.ra1) &&
                     !is_zero(bus.ra1);
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: init/reset sequences plus a vector table checked via an expectation queue.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   npass = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DW(32), .AW(5)) bus ();

  regfile_sb #(
    .DW(32), .AW(5), .ZERO_REG(1), .SP_IDX(2), .SP_INIT(32'h2ffc),
    .GP_IDX(3), .GP_INIT(32'h1800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ss;
    logic [4:0]  swa;
    logic [4:0]  a0, a1, ad;
    logic [31:0] e0, e1, ed;
    logic        b0, b1;
  } vec_t;

  typedef struct {
    logic [31:0] e0, e1, ed;
    logic        b0, b1;
  } exp_t;

  vec_t vt[17];
  exp_t q[$];

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                              logic ss, logic [4:0] swa,
                              logic [4:0] a0, logic [4:0] a1, logic [4:0] ad,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] ed,
                              logic b0, logic b1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ss = ss; v.swa = swa;
    v.a0 = a0; v.a1 = a1; v.ad = ad;
    v.e0 = e0; v.e1 = e1; v.ed = ed; v.b0 = b0; v.b1 = b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.sb_set = 1'b0; bus.sb_wa = '0;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Counts INIT cycles seen at negedges; returns at the negedge where init_done is first high.
  task automatic wait_init(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.init_done === 1'b1) return;
      n++;
    end
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    bus.ra0 = a;
    #1 chk(name, bus.rd0, exp);
  endtask

  initial begin
    int   n;
    exp_t e;

    vt[0]  = mk(0, 0, 0,            0, 0,  2, 3, 5,  32'h2ffc, 32'h1800, 0, 0, 0);
    vt[1]  = mk(1, 7, 32'h12345678, 0, 0,  7, 0, 7,  32'h12345678, 0, 32'h12345678, 0, 0);
    vt[2]  = mk(0, 0, 0,            0, 0,  7, 7, 2,  32'h12345678, 32'h12345678, 32'h2ffc, 0, 0);
    vt[3]  = mk(1, 0, 32'hffffffff, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0,            0, 0,  0, 0, 2,  0, 0, 32'h2ffc, 0, 0);
    vt[5]  = mk(0, 0, 0,            1, 9,  9, 2, 3,  0, 32'h2ffc, 32'h1800, 0, 0);
    vt[6]  = mk(0, 0, 0,            0, 0,  9, 9, 7,  0, 0, 32'h12345678, 1, 1);
    vt[7]  = mk(1, 9, 32'haa55,     0, 0,  9, 3, 9,  32'haa55, 32'h1800, 32'haa55, 0, 0);
    vt[8]  = mk(0, 0, 0,            0, 0,  9, 9, 9,  32'haa55, 32'haa55, 32'haa55, 0, 0);
    vt[9]  = mk(0, 0, 0,            1, 4,  7, 4, 4,  32'h12345678, 0, 0, 0, 0);
    vt[10] = mk(1, 4, 32'h44,       1, 4,  4, 4, 4,  32'h44, 32'h44, 32'h44, 0, 0);
    vt[11] = mk(0, 0, 0,            0, 0,  4, 4, 9,  32'h44, 32'h44, 32'haa55, 1, 1);
    vt[12] = mk(0, 0, 0,            1, 0,  0, 4, 0,  0, 32'h44, 0, 0, 1);
    vt[13] = mk(0, 0, 0,            0, 0,  0, 9, 0,  0, 32'haa55, 0, 0, 0);
    vt[14] = mk(1, 4, 32'h55,       1, 10, 4, 10, 4, 32'h55, 0, 32'h55, 0, 0);
    vt[15] = mk(0, 0, 0,            0, 0,  4, 10, 4, 32'h55, 0, 32'h55, 0, 1);
    vt[16] = mk(0, 0, 0,            1, 6,  5, 6, 3,  0, 0, 32'h1800, 0, 0);

    idle();
    bus.ra0 = '0; bus.ra1 = '0; bus.ra_dbg = '0;
    repeat (3) @(posedge clk);

    // Init sequence with WB/ID traffic that must be ignored during INIT.
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hdead;
    bus.sb_set = 1'b1; bus.sb_wa = 5'd5;
    pulse_rst();
    wait_init(n);
    idle();
    chk("init_len", 32'(n), 32'd32);
    chk("init_done", 32'(bus.init_done), 32'd1);
    rd_chk("x2_init", 5'd2, 32'h2ffc);
    rd_chk("x3_init", 5'd3, 32'h1800);
    rd_chk("x5_init", 5'd5, 32'h0);
    chk("busy_x5_init", 32'(bus.busy0), 32'd0);

    // Dirty some state in RUN, then reset mid-init.
    @(posedge clk); #1;
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h77;
    bus.sb_set = 1'b1; bus.sb_wa = 5'd20;
    @(posedge clk); #1;
    idle();
    bus.ra1 = 5'd20;
    rd_chk("x5_write", 5'd5, 32'h77);
    chk("busy_x20", 32'(bus.busy1), 32'd1);

    pulse_rst();
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    bus.we = 1'b1; bus.wa = 5'd2; bus.wd = 32'hdead;
    bus.ra0 = 5'd2; bus.ra_dbg = 5'd3; bus.ra1 = 5'd20;
    @(negedge clk);
    chk("init_rd0_gated", bus.rd0, 32'h0);
    chk("init_dbg_gated", bus.rd_dbg, 32'h0);
    chk("init_busy_gated", 32'(bus.busy1), 32'd0);
    chk("init_done_mid", 32'(bus.init_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle();
    wait_init(n);
    chk("reinit_len", 32'(n), 32'd32);
    rd_chk("x2_reinit", 5'd2, 32'h2ffc);
    rd_chk("x3_reinit", 5'd3, 32'h1800);
    rd_chk("x5_reinit", 5'd5, 32'h0);
    rd_chk("x31_reinit", 5'd31, 32'h0);

    // Vector table, expectations queued at drive time and retired at the negedge.
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      bus.we = vt[i].we; bus.wa = vt[i].wa; bus.wd = vt[i].wd;
      bus.sb_set = vt[i].ss; bus.sb_wa = vt[i].swa;
      bus.ra0 = vt[i].a0; bus.ra1 = vt[i].a1; bus.ra_dbg = vt[i].ad;
      e.e0 = vt[i].e0; e.e1 = vt[i].e1; e.ed = vt[i].ed;
      e.b0 = vt[i].b0; e.b1 = vt[i].b1;
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("v%0d_rd0", i), bus.rd0, e.e0);
      chk($sformatf("v%0d_rd1", i), bus.rd1, e.e1);
      chk($sformatf("v%0d_dbg", i), bus.rd_dbg, e.ed);
      chk($sformatf("v%0d_busy0", i), 32'(bus.busy0), 32'(e.b0));
      chk($sformatf("v%0d_busy1", i), 32'(bus.busy1), 32'(e.b1));
      @(posedge clk); #1;
    end
    idle();

    // sb[6] and sb[10] are set; reset must clear them and restore init values.
    bus.ra0 = 5'd6; bus.ra1 = 5'd10;
    #1 chk("busy_x6_pre", 32'(bus.busy0), 32'd1);
    pulse_rst();
    wait_init(n);
    chk("rst_init_len", 32'(n), 32'd32);
    bus.ra0 = 5'd6; bus.ra1 = 5'd10; bus.ra_dbg = 5'd2;
    #1;
    chk("busy_x6_post", 32'(bus.busy0), 32'd0);
    chk("busy_x10_post", 32'(bus.busy1), 32'd0);
    chk("dbg_x2_post", bus.rd_dbg, 32'h2ffc);
    rd_chk("x7_post", 5'd7, 32'h0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read register file for the pipelined CPU core.
- Adds a per-register pending-write scoreboard used for hazard detection.
- Has a sequenced reset-initialisation phase that walks every entry, so the storage array needs no parallel reset and maps to distributed RAM.
- Sits between ID (reads, scoreboard set on issue) and WB (write, scoreboard clear); the debug port feeds the PDU.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; DEPTH = 2**AW entries.
- ZERO_REG, 1, 1 = entry 0 hard-wired to zero (reads 0, writes discarded, never busy).
- SP_IDX, 2, index preloaded with SP_INIT during init.
- SP_INIT, 32'h2ffc, stack pointer init value (truncated/zero-extended to DW).
- GP_IDX, 3, index preloaded with GP_INIT during init.
- GP_INIT, 32'h1800, global pointer init value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ra0  in  AW  read port 0 address.
- rd0  out  DW  read port 0 data.
- ra1  in  AW  read port 1 address.
- rd1  out  DW  read port 1 data.
- ra_dbg  in  AW  debug read address (PDU).
- rd_dbg  out  DW  debug read data.
- we  in  1  write enable (WB).
- wa  in  AW  write address.
- wd  in  DW  write data.
- sb_set  in  1  mark sb_wa pending (ID issue of a reg-writing instruction).
- sb_wa  in  AW  destination to mark pending.
- busy0  out  1  ra0 has a pending write.
- busy1  out  1  ra1 has a pending write.
- init_done  out  1  high once initialisation is complete.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states INIT, RUN. The reset state is INIT with idx=0.
  - rst in any state, including mid-INIT, returns the FSM to INIT with idx=0 on the next edge.
- INIT: each cycle writes array[idx] and increments idx.
  - Value written: SP_INIT if idx==SP_IDX, GP_INIT if idx==GP_IDX, else 0.
  - Scoreboard bit idx is cleared in the same cycle.
  - The cycle with idx==DEPTH-1 transitions to RUN, so INIT lasts exactly DEPTH cycles after rst deasserts.
  - idx wraps only on rst; it never wraps on its own.
- init_done: 0 in INIT (and in the cycle rst is sampled), 1 in RUN. Registered output.
- During INIT:
  - we and sb_set are ignored.
  - rd0/rd1/rd_dbg = 0.
  - busy0/busy1 = 0.
- RUN reads are combinational, with write-first bypass:
  - rdX = 0 if ZERO_REG && raX==0.
  - Else rdX = wd if we && wa==raX.
  - Else rdX = array[raX].
  - Same rule for rd_dbg.
- RUN write: on the edge with we=1, array[wa] <= wd. If ZERO_REG and wa==0, nothing is written.
- Scoreboard sb[DEPTH-1:0]:
  - Edge with we=1 clears sb[wa].
  - Edge with sb_set=1 sets sb[sb_wa].
  - Same index set and cleared in the same cycle: set wins (the new producer is issued after the old one retires).
  - Different indices: both take effect.
  - Index 0 is never set when ZERO_REG=1.
  - Setting an already-set bit is legal; the bit stays 1. There is no counting, so a single outstanding writer per register is the pipeline's responsibility.
- busyX = sb[raX] & ~(we && wa==raX), forced 0 for raX==0 when ZERO_REG. A value bypassed this cycle is not busy.
- Latency: read 0 cycles; write visible through the array the cycle after the edge, and through the bypass in the same cycle.
- Widths: all address compares are AW bits; no sign extension.

Test Plan:
- Init sequence: assert rst 1 cycle, release.
  - init_done=0 for exactly 32 cycles, then 1.
  - rd0 reads: x2=32'h2ffc, x3=32'h1800, x5=0.
  - we=1, wa=5, wd=32'hdead applied during INIT is ignored: x5 still 0 after init.
- Reset mid-init: rst at INIT cycle 10.
  - init_done rises 32 cycles after this second release, not earlier.
  - Array contents match the init values.
- Bypass and x0: in RUN, we=1, wa=7, wd=32'h12345678, ra0=7 → rd0=32'h12345678 in the same cycle.
  - Next cycle with we=0 → still 32'h12345678.
  - we=1, wa=0, wd=32'hffffffff, ra1=0 → rd1=0 in that cycle and after.
- Scoreboard basic: sb_set=1, sb_wa=9 → next cycle ra0=9 gives busy0=1.
  - Then we=1, wa=9 → busy0=0 in that cycle (bypass).
  - After the edge: sb[9]=0, busy0 stays 0.
- Set/clear collision: sb[4]=1, then in one cycle we=1, wa=4 and sb_set=1, sb_wa=4 → after the edge busy1 (ra1=4) = 1.
  - Also: sb_set=1, sb_wa=0 → busy0 for ra0=0 stays 0.
- Debug port and reset-clears-scoreboard: sb[6] set; assert rst → after init, busy0 (ra0=6) = 0 and rd_dbg for ra_dbg=2 is 32'h2ffc.
